// File: rtl/rv32_ctrl_pkg.sv
// Shared constants and types for the RV32I multi-cycle control unit.
// Opcode, ALU, immediate, writeback, trap-cause and FSM state encodings.
package rv32_ctrl_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b0001;
    localparam logic [3:0] ALU_SLL    = 4'b0010;
    localparam logic [3:0] ALU_SLT    = 4'b0011;
    localparam logic [3:0] ALU_SLTU   = 4'b0100;
    localparam logic [3:0] ALU_XOR    = 4'b0101;
    localparam logic [3:0] ALU_SRL    = 4'b0110;
    localparam logic [3:0] ALU_SRA    = 4'b0111;
    localparam logic [3:0] ALU_OR     = 4'b1000;
    localparam logic [3:0] ALU_AND    = 4'b1001;
    localparam logic [3:0] ALU_PASS_B = 4'b1111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] M2R_ALU  = 2'b00;
    localparam logic [1:0] M2R_LOAD = 2'b01;
    localparam logic [1:0] M2R_PC4  = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_IMEM    = 2'b10;
    localparam logic [1:0] CAUSE_DMEM    = 2'b11;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_DECODE  = 3'd2;
    localparam logic [2:0] ST_EXECUTE = 3'd3;
    localparam logic [2:0] ST_MEM     = 3'd4;
    localparam logic [2:0] ST_WB      = 3'd5;
    localparam logic [2:0] ST_TRAP    = 3'd6;

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_R,
        CLS_I,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC
    } ins_class_t;

    typedef struct packed {
        ins_class_t cls;
        logic       operand_a;
        logic       operand_b;
        logic [2:0] imm_sel;
        logic [3:0] alu_control;
    } ctrl_word_t;

    // alt selects SUB for fun3=000 and SRA for fun3=101
    function automatic logic [3:0] alu_from_fun3(input logic [2:0] fun3, input logic alt);
        case (fun3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32_ctrl_word_dec.sv
// Combinational decode of opcode/fun3/fun7 into a control word plus an
// illegal-encoding flag; latched by the FSM during DECODE.
module rv32_ctrl_word_dec
    import rv32_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] fun3,
    input  logic       fun7,
    output ctrl_word_t cw,
    output logic       illegal
);

    always_comb begin
        cw      = '0;
        illegal = 1'b0;
        case (opcode)
            OPC_OP: begin
                cw.cls         = CLS_R;
                cw.alu_control = alu_from_fun3(fun3, fun7);
                illegal        = fun7 && (fun3 != 3'b000) && (fun3 != 3'b101);
            end
            OPC_OP_IMM: begin
                cw.cls         = CLS_I;
                cw.operand_b   = 1'b1;
                // bit 30 is immediate data except for the shift encodings
                cw.alu_control = alu_from_fun3(fun3, fun7 && (fun3 == 3'b101));
                illegal        = (fun3 == 3'b001) && fun7;
            end
            OPC_LOAD: begin
                cw.cls       = CLS_LOAD;
                cw.operand_b = 1'b1;
                illegal      = (fun3 == 3'b011) || (fun3 == 3'b110) || (fun3 == 3'b111);
            end
            OPC_STORE: begin
                cw.cls       = CLS_STORE;
                cw.operand_b = 1'b1;
                cw.imm_sel   = IMM_S;
                illegal      = (fun3 > 3'b010);
            end
            OPC_BRANCH: begin
                cw.cls       = CLS_BRANCH;
                cw.operand_a = 1'b1;
                cw.operand_b = 1'b1;
                cw.imm_sel   = IMM_B;
                illegal      = (fun3 == 3'b010) || (fun3 == 3'b011);
            end
            OPC_JAL: begin
                cw.cls       = CLS_JAL;
                cw.operand_a = 1'b1;
                cw.operand_b = 1'b1;
                cw.imm_sel   = IMM_J;
            end
            OPC_JALR: begin
                cw.cls       = CLS_JALR;
                cw.operand_b = 1'b1;
                illegal      = (fun3 != 3'b000);
            end
            OPC_LUI: begin
                cw.cls         = CLS_LUI;
                cw.operand_b   = 1'b1;
                cw.imm_sel     = IMM_U;
                cw.alu_control = ALU_PASS_B;
            end
            OPC_AUIPC: begin
                cw.cls       = CLS_AUIPC;
                cw.operand_a = 1'b1;
                cw.operand_b = 1'b1;
                cw.imm_sel   = IMM_U;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/mem/wb,
// holds the latched control word, memory-wait timeout and instret counter.
//
//   state   | meaning
//   IDLE    | post-reset, all strobes low
//   FETCH   | imem request, IR load on ready
//   DECODE  | latch control word, check legality
//   EXECUTE | ALU operation, branches/jumps retire here
//   MEM     | data access, stores retire on ready
//   WB      | register writeback, retire
//   TRAP    | sticky fault, exits only on reset
module rv32_multicycle_ctrl
    import rv32_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter bit TIMEOUT_EN  = 1'b1,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       fun3,
    input  logic             fun7,
    input  logic             br_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_en,
    output logic             pc_en,
    output logic             next_sel,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_write,
    output logic [1:0]       mem_to_reg,
    output logic             operand_a,
    output logic             operand_b,
    output logic [2:0]       imm_sel,
    output logic [3:0]       alu_control,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] instret
);

    localparam int            TW       = $clog2(MEM_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

    logic [2:0]    state, state_nxt;
    ctrl_word_t    cw_q, cw_dec;
    logic          illegal;
    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic [1:0]    cause_q, cause_nxt;
    logic          retire;
    logic          tmo_at_last;
    logic          tmo_hit;

    rv32_ctrl_word_dec u_dec (
        .opcode  (opcode),
        .fun3    (fun3),
        .fun7    (fun7),
        .cw      (cw_dec),
        .illegal (illegal)
    );

    assign tmo_at_last = (tmo_cnt == TMO_LAST);
    assign tmo_hit     = TIMEOUT_EN && tmo_at_last;

    // Counter is zero outside the wait loops, so every FETCH/MEM entry starts at 0
    always_comb begin
        state_nxt = state;
        tmo_nxt   = '0;
        cause_nxt = cause_q;
        retire    = 1'b0;
        case (state)
            ST_IDLE: state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (imem_ready) begin
                    state_nxt = ST_DECODE;
                end else if (tmo_hit) begin
                    state_nxt = ST_TRAP;
                    cause_nxt = CAUSE_IMEM;
                end else begin
                    tmo_nxt = tmo_at_last ? tmo_cnt : tmo_cnt + 1'b1;
                end
            end
            ST_DECODE: begin
                if (illegal) begin
                    state_nxt = ST_TRAP;
                    cause_nxt = CAUSE_ILLEGAL;
                end else begin
                    state_nxt = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                case (cw_q.cls)
                    CLS_BRANCH, CLS_JAL, CLS_JALR: begin
                        state_nxt = ST_FETCH;
                        retire    = 1'b1;
                    end
                    CLS_LOAD, CLS_STORE: state_nxt = ST_MEM;
                    default:             state_nxt = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    if (cw_q.cls == CLS_STORE) begin
                        state_nxt = ST_FETCH;
                        retire    = 1'b1;
                    end else begin
                        state_nxt = ST_WB;
                    end
                end else if (tmo_hit) begin
                    state_nxt = ST_TRAP;
                    cause_nxt = CAUSE_DMEM;
                end else begin
                    tmo_nxt = tmo_at_last ? tmo_cnt : tmo_cnt + 1'b1;
                end
            end
            ST_WB: begin
                state_nxt = ST_FETCH;
                retire    = 1'b1;
            end
            ST_TRAP: state_nxt = ST_TRAP;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cw_q    <= '0;
            tmo_cnt <= '0;
            cause_q <= CAUSE_NONE;
            instret <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_nxt;
            cause_q <= cause_nxt;
            if (state == ST_DECODE) begin
                cw_q <= cw_dec;
            end
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

    always_comb begin
        imem_req    = 1'b0;
        ir_en       = 1'b0;
        pc_en       = 1'b0;
        next_sel    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = M2R_ALU;
        operand_a   = 1'b0;
        operand_b   = 1'b0;
        imm_sel     = IMM_I;
        alu_control = ALU_ADD;
        trap        = 1'b0;
        if (state == ST_EXECUTE || state == ST_MEM || state == ST_WB) begin
            operand_a   = cw_q.operand_a;
            operand_b   = cw_q.operand_b;
            imm_sel     = cw_q.imm_sel;
            alu_control = cw_q.alu_control;
        end
        case (state)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_en    = imem_ready;
            end
            ST_EXECUTE: begin
                case (cw_q.cls)
                    CLS_BRANCH: begin
                        pc_en    = 1'b1;
                        next_sel = br_taken;
                    end
                    CLS_JAL, CLS_JALR: begin
                        pc_en      = 1'b1;
                        next_sel   = 1'b1;
                        reg_write  = 1'b1;
                        mem_to_reg = M2R_PC4;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cw_q.cls == CLS_STORE);
                pc_en    = (cw_q.cls == CLS_STORE) && dmem_ready;
            end
            ST_WB: begin
                reg_write  = 1'b1;
                pc_en      = 1'b1;
                mem_to_reg = (cw_q.cls == CLS_LOAD) ? M2R_LOAD : M2R_ALU;
            end
            ST_TRAP: trap = 1'b1;
            default: ;
        endcase
    end

    assign trap_cause = cause_q;

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Directed-vector bench for rv32_multicycle_ctrl: instruction sequencing,
// memory waits, illegal encodings, timeouts and asynchronous reset.
module tb_rv32_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  opcode = '0;
    logic [2:0]  fun3 = '0;
    logic        fun7 = 1'b0;
    logic        br_taken = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, ir_en, pc_en, next_sel, dmem_req, dmem_we, reg_write;
    logic [1:0]  mem_to_reg;
    logic        operand_a, operand_b;
    logic [2:0]  imm_sel;
    logic [3:0]  alu_control;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [31:0] instret;
    logic [20:0] obs;

    int n_vec = 0;
    int n_err = 0;
    int exp_ret = 0;

    logic [6:0] t_op;
    logic [2:0] t_f3;
    logic       t_f7;
    logic [3:0] t_alu;
    logic       t_oa, t_ob;
    logic [2:0] t_imm;

    // {opcode, fun3, fun7, alu_control, operand_a, operand_b, imm_sel}
    localparam logic [19:0] ALU_TBL [15] = '{
        {7'h33, 3'b000, 1'b0, 4'b0000, 1'b0, 1'b0, 3'b000},
        {7'h33, 3'b000, 1'b1, 4'b0001, 1'b0, 1'b0, 3'b000},
        {7'h33, 3'b001, 1'b0, 4'b0010, 1'b0, 1'b0, 3'b000},
        {7'h33, 3'b010, 1'b0, 4'b0011, 1'b0, 1'b0, 3'b000},
        {7'h33, 3'b011, 1'b0, 4'b0100, 1'b0, 1'b0, 3'b000},
        {7'h33, 3'b100, 1'b0, 4'b0101, 1'b0, 1'b0, 3'b000},
        {7'h33, 3'b101, 1'b0, 4'b0110, 1'b0, 1'b0, 3'b000},
        {7'h33, 3'b101, 1'b1, 4'b0111, 1'b0, 1'b0, 3'b000},
        {7'h33, 3'b110, 1'b0, 4'b1000, 1'b0, 1'b0, 3'b000},
        {7'h33, 3'b111, 1'b0, 4'b1001, 1'b0, 1'b0, 3'b000},
        {7'h13, 3'b000, 1'b1, 4'b0000, 1'b0, 1'b1, 3'b000},
        {7'h13, 3'b101, 1'b1, 4'b0111, 1'b0, 1'b1, 3'b000},
        {7'h13, 3'b001, 1'b0, 4'b0010, 1'b0, 1'b1, 3'b000},
        {7'h37, 3'b000, 1'b0, 4'b1111, 1'b0, 1'b1, 3'b100},
        {7'h17, 3'b000, 1'b0, 4'b0000, 1'b1, 1'b1, 3'b100}
    };

    // {opcode, fun3, fun7}
    localparam logic [10:0] ILL_TBL [6] = '{
        {7'h33, 3'b001, 1'b1},
        {7'h13, 3'b001, 1'b1},
        {7'h03, 3'b011, 1'b0},
        {7'h23, 3'b011, 1'b0},
        {7'h63, 3'b010, 1'b0},
        {7'h67, 3'b001, 1'b0}
    };

    rv32_multicycle_ctrl #(
        .MEM_TIMEOUT (16),
        .TIMEOUT_EN  (1'b1),
        .CNT_W       (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .fun3        (fun3),
        .fun7        (fun7),
        .br_taken    (br_taken),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .imem_req    (imem_req),
        .ir_en       (ir_en),
        .pc_en       (pc_en),
        .next_sel    (next_sel),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .imm_sel     (imm_sel),
        .alu_control (alu_control),
        .trap        (trap),
        .trap_cause  (trap_cause),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    assign obs = {imem_req, ir_en, pc_en, next_sel, dmem_req, dmem_we, reg_write,
                  mem_to_reg, operand_a, operand_b, imm_sel, alu_control, trap, trap_cause};

    function automatic logic [20:0] pk(input logic ireq, input logic ien, input logic pcen,
                                       input logic nsel, input logic dreq, input logic dwe,
                                       input logic rw, input logic [1:0] m2r, input logic oa,
                                       input logic ob, input logic [2:0] imm,
                                       input logic [3:0] alu, input logic tr,
                                       input logic [1:0] cause);
        return {ireq, ien, pcen, nsel, dreq, dwe, rw, m2r, oa, ob, imm, alu, tr, cause};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic chk_out(input string tag, input logic [20:0] want);
        #1;
        chk(tag, {11'd0, obs}, {11'd0, want});
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Asserts reset mid-cycle, checks the asynchronous clear, releases; ends in FETCH.
    task automatic do_reset();
        rst        = 1'b1;
        br_taken   = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        chk_out("rst_out", 21'd0);
        chk("rst_instret", instret, 32'd0);
        exp_ret = 0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        chk_out("idle", 21'd0);
        cyc();
    endtask

    // From FETCH: ready immediately, pass through DECODE; ends in EXECUTE (or TRAP).
    task automatic fetch(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode     = op;
        fun3       = f3;
        fun7       = f7;
        imem_ready = 1'b1;
        chk_out("fetch", pk(1, 1, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 4'b0000, 0, 2'b00));
        cyc();
        imem_ready = 1'b0;
        chk_out("decode", 21'd0);
        cyc();
    endtask

    task automatic alu_instr(input int i);
        {t_op, t_f3, t_f7, t_alu, t_oa, t_ob, t_imm} = ALU_TBL[i];
        fetch(t_op, t_f3, t_f7);
        chk_out($sformatf("exec%0d", i),
                pk(0, 0, 0, 0, 0, 0, 0, 2'b00, t_oa, t_ob, t_imm, t_alu, 0, 2'b00));
        cyc();
        chk_out($sformatf("wb%0d", i),
                pk(0, 0, 1, 0, 0, 0, 1, 2'b00, t_oa, t_ob, t_imm, t_alu, 0, 2'b00));
        cyc();
        exp_ret++;
        chk($sformatf("instret%0d", i), instret, exp_ret);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        do_reset();

        for (int i = 0; i < 15; i++) alu_instr(i);

        // LW with dmem_ready arriving in the 4th MEM cycle
        fetch(7'h03, 3'b010, 1'b0);
        chk_out("lw_exec", pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 3'b000, 4'b0000, 0, 2'b00));
        cyc();
        for (int k = 0; k < 4; k++) begin
            dmem_ready = (k == 3);
            chk_out("lw_mem", pk(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 1, 3'b000, 4'b0000, 0, 2'b00));
            cyc();
        end
        dmem_ready = 1'b0;
        chk_out("lw_wb", pk(0, 0, 1, 0, 0, 0, 1, 2'b01, 0, 1, 3'b000, 4'b0000, 0, 2'b00));
        cyc();
        exp_ret++;
        chk("lw_instret", instret, exp_ret);

        // SW completing immediately
        fetch(7'h23, 3'b010, 1'b0);
        chk_out("sw_exec", pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 1, 3'b001, 4'b0000, 0, 2'b00));
        cyc();
        dmem_ready = 1'b1;
        chk_out("sw_mem", pk(0, 0, 1, 0, 1, 1, 0, 2'b00, 0, 1, 3'b001, 4'b0000, 0, 2'b00));
        cyc();
        dmem_ready = 1'b0;
        exp_ret++;
        chk("sw_instret", instret, exp_ret);

        // BEQ taken, then not taken
        for (int k = 0; k < 2; k++) begin
            fetch(7'h63, 3'b000, 1'b0);
            br_taken = (k == 0);
            chk_out(k == 0 ? "beq_taken" : "beq_not",
                    pk(0, 0, 1, k == 0, 0, 0, 0, 2'b00, 1, 1, 3'b010, 4'b0000, 0, 2'b00));
            cyc();
            br_taken = 1'b0;
            exp_ret++;
            chk("beq_instret", instret, exp_ret);
        end

        fetch(7'h6F, 3'b000, 1'b0);
        chk_out("jal", pk(0, 0, 1, 1, 0, 0, 1, 2'b10, 1, 1, 3'b011, 4'b0000, 0, 2'b00));
        cyc();
        fetch(7'h67, 3'b000, 1'b0);
        chk_out("jalr", pk(0, 0, 1, 1, 0, 0, 1, 2'b10, 0, 1, 3'b000, 4'b0000, 0, 2'b00));
        cyc();
        exp_ret += 2;
        chk("jump_instret", instret, exp_ret);

        // Unknown opcode traps and stays; instret untouched
        fetch(7'h7F, 3'b000, 1'b0);
        for (int k = 0; k < 3; k++) begin
            imem_ready = k[0];
            chk_out("trap_ill", pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 4'b0000, 1, 2'b01));
            chk("trap_instret", instret, exp_ret);
            cyc();
        end

        // imem_ready in the 16th FETCH cycle: ready wins over the limit
        do_reset();
        opcode = 7'h33;
        fun3   = 3'b000;
        fun7   = 1'b0;
        for (int k = 0; k < 16; k++) begin
            imem_ready = (k == 15);
            chk_out(k == 15 ? "fetch_late" : "fetch_wait",
                    pk(1, k == 15, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 4'b0000, 0, 2'b00));
            cyc();
        end
        imem_ready = 1'b0;
        chk_out("late_decode", 21'd0);
        cyc();
        cyc();
        chk_out("late_wb", pk(0, 0, 1, 0, 0, 0, 1, 2'b00, 0, 0, 3'b000, 4'b0000, 0, 2'b00));
        cyc();
        chk("late_instret", instret, 32'd1);

        // Reset asserted while a store is waiting in MEM
        fetch(7'h23, 3'b000, 1'b0);
        cyc();
        chk_out("sw_wait", pk(0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 1, 3'b001, 4'b0000, 0, 2'b00));
        cyc();
        chk_out("sw_wait2", pk(0, 0, 0, 0, 1, 1, 0, 2'b00, 0, 1, 3'b001, 4'b0000, 0, 2'b00));
        do_reset();
        alu_instr(0);

        for (int i = 0; i < 6; i++) begin
            do_reset();
            {t_op, t_f3, t_f7} = ILL_TBL[i];
            fetch(t_op, t_f3, t_f7);
            chk_out($sformatf("illegal%0d", i),
                    pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 4'b0000, 1, 2'b01));
            cyc();
            chk_out($sformatf("illegal_hold%0d", i),
                    pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 4'b0000, 1, 2'b01));
        end

        // imem timeout after 16 FETCH cycles
        do_reset();
        for (int k = 0; k < 16; k++) begin
            chk_out("imem_wait", pk(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 4'b0000, 0, 2'b00));
            cyc();
        end
        chk_out("imem_tmo", pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 4'b0000, 1, 2'b10));

        // dmem timeout after 16 MEM cycles
        do_reset();
        fetch(7'h03, 3'b000, 1'b0);
        cyc();
        for (int k = 0; k < 16; k++) begin
            chk_out("dmem_wait", pk(0, 0, 0, 0, 1, 0, 0, 2'b00, 0, 1, 3'b000, 4'b0000, 0, 2'b00));
            cyc();
        end
        chk_out("dmem_tmo", pk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 4'b0000, 1, 2'b11));
        chk("dmem_tmo_instret", instret, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
